// File: rtl/dsp_ctrl_seq.sv
// -----------------------------------------------------------------------------
// dsp_ctrl_seq
//
// Control sequencer for a DSP multiply-accumulate slice. One accepted start
// runs a MAC of `len` product terms:
//   CLR   : clears the INMODE and P registers for one cycle
//   FIRST : first term, P <= M
//   ACC   : remaining terms, P <= P + M
//   DRAIN : waits PIPE_LAT cycles for the slice pipeline to empty
//   DONE  : one-cycle done pulse
// Terms are consumed only on cycles where sample_vld is high. A low
// sample_vld stalls the run.
//
// Ports
//   clk        rising-edge clock
//   RSTn       asynchronous active-low reset
//   start      run request, only looked at in IDLE
//   len        number of product terms, latched on an accepted start
//   use_preadd 1 = (D+/-A)*B, 0 = A*B, latched on an accepted start
//   sub_mode   1 = pre-adder computes D-A, latched on an accepted start
//   sample_vld operands are present on A/B/D this cycle
//   sample_rdy term consumed this cycle (combinational)
//   busy       run in progress (CLR through DRAIN)
//   done       one-cycle end-of-run pulse, never together with busy
//   INMODE     slice INMODE, constant for the whole run
//   OPMODE     slice OPMODE
//   ALUMODE    slice ALUMODE, always add (Z + X + Y)
//   CEINMODE   INMODE register clock enable (combinational)
//   CECTRL     OPMODE/ALUMODE register clock enable (combinational)
//   RSTINMODE  clear pulse to the INMODE register
//   RSTP       clear pulse to the P register
//
// PIPE_LAT must be at least 1.
// -----------------------------------------------------------------------------
module dsp_ctrl_seq #(
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             use_preadd,
    input  logic             sub_mode,
    input  logic             sample_vld,
    output logic             sample_rdy,
    output logic             busy,
    output logic             done,
    output logic [4:0]       INMODE,
    output logic [6:0]       OPMODE,
    output logic [3:0]       ALUMODE,
    output logic             CEINMODE,
    output logic             CECTRL,
    output logic             RSTINMODE,
    output logic             RSTP
);

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(PIPE_LAT - 1);

    localparam logic [6:0] OPM_FIRST = 7'b0000101;  // Z=0, X/Y=M
    localparam logic [6:0] OPM_ACC   = 7'b0100101;  // Z=P, X/Y=M

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FIRST,
        S_ACC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic [4:0]       inmode_q, inmode_d;
    logic [6:0]       opmode_q, opmode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clr_q, clr_d;
    logic             term_phase;

    assign term_phase = (state_q == S_FIRST) || (state_q == S_ACC);

    // Term handshake and slice clock enables follow sample_vld directly so a
    // stalled cycle neither consumes a sample nor clocks the slice registers.
    assign sample_rdy = term_phase && sample_vld;
    assign CEINMODE   = sample_rdy;
    assign CECTRL     = sample_rdy;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            drn_q    <= '0;
            inmode_q <= '0;
            opmode_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            drn_q    <= drn_d;
            inmode_q <= inmode_d;
            opmode_q <= opmode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            clr_q    <= clr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        drn_d    = drn_q;
        inmode_d = inmode_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = len;
                    // INMODE is fixed at start so it stays put for the run.
                    if (!use_preadd) begin
                        inmode_d = 5'b00000;
                    end else if (sub_mode) begin
                        inmode_d = 5'b01100;
                    end else begin
                        inmode_d = 5'b00100;
                    end
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                cnt_d   = len_q;
                state_d = (len_q != '0) ? S_FIRST : S_DONE;
            end
            S_FIRST, S_ACC: begin
                if (sample_vld) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                        drn_d   = DRN_LOAD;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they line up
        // with the state they describe.
        busy_d   = (state_d == S_CLR) || (state_d == S_FIRST) ||
                   (state_d == S_ACC) || (state_d == S_DRAIN);
        done_d   = (state_d == S_DONE);
        clr_d    = (state_d == S_CLR);
        opmode_d = 7'b0000000;
        if (state_d == S_FIRST) begin
            opmode_d = OPM_FIRST;
        end else if (state_d == S_ACC) begin
            opmode_d = OPM_ACC;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign INMODE    = inmode_q;
    assign OPMODE    = opmode_q;
    assign ALUMODE   = 4'b0000;  // plain add in every state
    assign RSTINMODE = clr_q;
    assign RSTP      = clr_q;

endmodule

// File: doc/dsp_ctrl_seq.md
DSP_CTRL_SEQ -- requirements
Module: dsp_ctrl_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the term-count input and counter.
REQ-002 SHALL have parameter PIPE_LAT, default 4, drain cycles after the last issued term (covers INMODE/M/P register stages).
REQ-003 SHALL have ports, in order:
  - clk  input  1  rising-edge clock.
  - RSTn  input  1  reset, asynchronous, active-low.
  - start  input  1  request a MAC run; sampled only in IDLE.
  - len  input  CNT_W  number of product terms; latched on accepted start.
  - use_preadd  input  1  1 = (D±A)*B, 0 = A*B; latched on accepted start.
  - sub_mode  input  1  1 = pre-adder subtracts (D−A); latched on accepted start.
  - sample_vld  input  1  operand samples present on A/B/D this cycle.
  - sample_rdy  output  1  term consumed this cycle.
  - busy  output  1  run in progress.
  - done  output  1  one-cycle end-of-run pulse.
  - INMODE  output  5  to the slice INMODE input.
  - OPMODE  output  7  to the slice OPMODE input.
  - ALUMODE  output  4  to the slice ALUMODE input.
  - CEINMODE  output  1  INMODE register clock enable.
  - CECTRL  output  1  OPMODE/ALUMODE register clock enable.
  - RSTINMODE  output  1  synchronous clear pulse to the INMODE register.
  - RSTP  output  1  synchronous clear pulse to the P register.

Function
REQ-004 SHALL implement FSM states IDLE, CLR, FIRST, ACC, DRAIN, DONE.
REQ-005 IDLE: start=1 SHALL latch len/use_preadd/sub_mode, go to CLR, and assert busy from the next cycle.
REQ-006 CLR SHALL last exactly 1 cycle with RSTINMODE=1 and RSTP=1, then go to FIRST (len≠0) or DONE (len=0).
REQ-007 INMODE SHALL be 5'b00000 when use_preadd=0, 5'b00100 when use_preadd=1 and sub_mode=0, and 5'b01100 when use_preadd=1 and sub_mode=1; it SHALL hold its value for the whole run.
REQ-008 ALUMODE SHALL be 4'b0000 in all states.
REQ-009 FIRST SHALL drive OPMODE=7'b0000101 (Z=0, X/Y=M).
REQ-010 ACC SHALL drive OPMODE=7'b0100101 (Z=P).
REQ-011 In FIRST and ACC: sample_rdy, CEINMODE and CECTRL SHALL all equal sample_vld; with sample_vld=0 the state and counter SHALL hold (stall).
REQ-012 The remaining-term counter SHALL load len in CLR and decrement on each sample_rdy.
REQ-013 FIRST SHALL go to ACC on sample_rdy when count>1, or to DRAIN on sample_rdy when count==1.
REQ-014 ACC SHALL go to DRAIN on the sample_rdy that consumes the last term.
REQ-015 Total sample_rdy pulses per run SHALL equal len exactly.
REQ-016 DRAIN SHALL last exactly PIPE_LAT cycles with sample_rdy=0, CEINMODE=0 and CECTRL=0, then go to DONE.
REQ-017 DONE SHALL assert done=1 for 1 cycle with busy=0, then go to IDLE.
REQ-018 done SHALL never coincide with busy=1.
REQ-019 start while busy=1 or in DONE SHALL be ignored; start in IDLE on the cycle after DONE SHALL be accepted.
REQ-020 Outside FIRST/ACC: sample_rdy=0, CEINMODE=0, CECTRL=0, OPMODE=7'b0000000.
REQ-021 Counter arithmetic SHALL be unsigned CNT_W bits; len=2^CNT_W−1 SHALL complete without wrap.
REQ-022 All outputs SHALL be registered, except sample_rdy, CEINMODE and CECTRL, which are combinational from state and sample_vld.

Reset
REQ-023 RSTn=0 SHALL asynchronously force IDLE, counter=0, latched controls=0, and all outputs 0, including busy, done, RSTINMODE and RSTP.
REQ-024 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after RSTn deasserts SHALL behave as from power-up.

Verification
REQ-025 len=3, use_preadd=0, sample_vld=1 constant -> RSTP pulse 1 cycle after start; sample_rdy high 3 consecutive cycles with OPMODE 0000101, 0100101, 0100101; done exactly 4+PIPE_LAT... cycles after CLR (1+3+4 with default PIPE_LAT).
REQ-026 len=4, sample_vld toggling 1,0,1,0,... -> exactly 4 sample_rdy pulses; counter and state held on vld=0 cycles; CEINMODE mirrors sample_rdy.
REQ-027 len=0 -> CLR then DONE; no sample_rdy; done 2 cycles after start.
REQ-028 use_preadd=1, sub_mode=1 -> INMODE=5'b01100 throughout FIRST/ACC; start pulses during the run produce no effect.
REQ-029 RSTn low during ACC with len=10 -> all outputs 0 immediately; no done; a new run with len=2 completes normally.
REQ-030 Back-to-back: start asserted the cycle after done -> accepted; second run's RSTP pulse occurs 1 cycle later.
